// File: rtl/banco_registradores_if.sv
// Register-file access bundle: one write port and two combinational read ports.
// The master side drives addresses and write data; the slave returns read data.
interface banco_registradores_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;

  modport master (
    output RegWrite, WriteRegister, data, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, data, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/banco_registradores.sv
// MIPS-style 32x32 register file, $zero hardwired, two async reads, one sync write.
// Define BANCO_REG_BYPASS_EN to forward same-cycle write data to matching read ports.
module banco_registradores #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  banco_registradores_if.slave  bus
);

  if (NUM_REGS != 2**ADDR_W) begin : g_bad_cfg
    $error("banco_registradores: NUM_REGS must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0]            regs_q [NUM_REGS];
  logic [DATA_W-1:0]            regs_d [NUM_REGS];
  logic [1:0][ADDR_W-1:0]       rd_addr;

  assign rd_addr = {bus.ReadRegister2, bus.ReadRegister1};

  always_comb begin
    regs_d = regs_q;
    if (bus.RegWrite && (bus.WriteRegister != '0)) begin
      regs_d[bus.WriteRegister] = bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] rd_val;
      always_comb begin
        // Entry 0 is forced on read so it is zero even before the first reset.
        rd_val = (rd_addr[gi] == '0) ? '0 : regs_q[rd_addr[gi]];
`ifdef BANCO_REG_BYPASS_EN
        if (bus.RegWrite && !rst && (bus.WriteRegister != '0) &&
            (rd_addr[gi] == bus.WriteRegister)) begin
          rd_val = bus.data;
        end
`endif
      end
    end
  endgenerate

  assign bus.ReadData1 = g_rd[0].rd_val;
  assign bus.ReadData2 = g_rd[1].rd_val;

endmodule

// File: tb/tb_banco_registradores.sv
// Scoreboard bench for banco_registradores: stimulus queues expected read data,
// a negedge monitor pops and compares whenever a check strobe is raised.
module tb_banco_registradores;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct {
    string             name;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
  } exp_t;

  logic clk;
  logic rst;
  logic chk_valid;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  banco_registradores_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  banco_registradores #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: samples mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        tests_run    = tests_run + 1;
        tests_failed = tests_failed + 1;
        $display("FAIL scoreboard_underflow: got rd1=%0d rd2=%0d with no expected entry",
                 bus.ReadData1, bus.ReadData2);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        tests_run = tests_run + 2;
        if (bus.ReadData1 !== e.e1) begin
          tests_failed = tests_failed + 1;
          $display("FAIL %s port1: got 0x%08h expected 0x%08h", e.name, bus.ReadData1, e.e1);
        end else begin
          $display("[TB] %s port1 rd[%0d]=0x%08h ok", e.name, bus.ReadRegister1, bus.ReadData1);
        end
        if (bus.ReadData2 !== e.e2) begin
          tests_failed = tests_failed + 1;
          $display("FAIL %s port2: got 0x%08h expected 0x%08h", e.name, bus.ReadData2, e.e2);
        end else begin
          $display("[TB] %s port2 rd[%0d]=0x%08h ok", e.name, bus.ReadRegister2, bus.ReadData2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = a;
    bus.data          = d;
    step();
    bus.RegWrite      = 1'b0;
  endtask

  // Queue the expectation, set the read addresses, hold for one cycle.
  task automatic check(input string name,
                       input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] e1,
                       input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    exp_q.push_back(e);
    bus.ReadRegister1 = a1;
    bus.ReadRegister2 = a2;
    chk_valid = 1'b1;
    step();
    chk_valid = 1'b0;
  endtask

  logic [DATA_W-1:0] exp_same_cycle;

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    chk_valid         = 1'b0;
    rst               = 1'b1;
    bus.RegWrite      = 1'b0;
    bus.WriteRegister = '0;
    bus.data          = '0;
    bus.ReadRegister1 = '0;
    bus.ReadRegister2 = '0;
`ifdef BANCO_REG_BYPASS_EN
    exp_same_cycle = 32'd99;
`else
    exp_same_cycle = 32'd180;
`endif

    step();
    step();
    rst = 1'b0;

    check("reset_state", 5'd5, 32'd0, 5'd31, 32'd0);

    for (int i = 1; i < 32; i++) begin
      wr(ADDR_W'(i), DATA_W'(12 * i));
    end
    check("fill_26_27", 5'd26, 32'd312, 5'd27, 32'd324);
    check("fill_1_31",  5'd1,  32'd12,  5'd31, 32'd372);

    wr(5'd18, 32'd70);
    check("overwrite_18", 5'd18, 32'd70, 5'd27, 32'd324);

    bus.RegWrite      = 1'b0;
    bus.WriteRegister = 5'd18;
    bus.data          = 32'd15;
    step();
    step();
    step();
    check("write_disable", 5'd18, 32'd70, 5'd0, 32'd0);

    wr(5'd0, 32'hDEADBEEF);
    check("zero_reg", 5'd0, 32'd0, 5'd0, 32'd0);

    // Same-address dual read while a write to that address is pending.
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd15;
    bus.data          = 32'd99;
    check("same_cycle_before", 5'd15, exp_same_cycle, 5'd15, exp_same_cycle);
    bus.RegWrite      = 1'b0;
    check("same_cycle_after", 5'd15, 32'd99, 5'd15, 32'd99);

    rst               = 1'b1;
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = 5'd30;
    bus.data          = 32'd5;
    step();
    rst          = 1'b0;
    bus.RegWrite = 1'b0;
    check("reset_mid_30_26", 5'd30, 32'd0, 5'd26, 32'd0);
    check("reset_mid_18_31", 5'd18, 32'd0, 5'd31, 32'd0);

    wr(5'd7, 32'h1234_5678);
    check("post_reset_write", 5'd7, 32'h1234_5678, 5'd30, 32'd0);

    step();
    tests_run = tests_run + 1;
    if (exp_q.size() != 0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
- MIPS-style general-purpose register file: 32 registers × 32 bits.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Sits in the datapath decode stage, between instruction decode and the ALU.
- Register 0 ($zero) is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- RegWrite  input  1  write enable.
- WriteRegister  input  ADDR_W  destination register address.
- data  input  DATA_W  write data.
- ReadRegister1  input  ADDR_W  read port 1 address.
- ReadRegister2  input  ADDR_W  read port 2 address.
- ReadData1  output  DATA_W  contents of ReadRegister1.
- ReadData2  output  DATA_W  contents of ReadRegister2.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (rst). Reset is sampled only on the rising edge of clk.
- Reset:
  - On a rising edge with rst=1, all registers become 0.
  - rst has priority over RegWrite; a write in a reset cycle is discarded.
  - Outputs follow the cleared contents immediately after that edge, so both read ports show 0.
- Write:
  - On a rising edge with rst=0 and RegWrite=1, reg[WriteRegister] <= data.
  - With RegWrite=0, no register changes, whatever WriteRegister or data hold.
- Register 0:
  - Writes to address 0 are ignored.
  - Reads of address 0 always return 0.
- Read:
  - Purely combinational: ReadDataN = reg[ReadRegisterN].
  - No clock latency; outputs change within the same cycle the address changes.
- Both ports may read the same address simultaneously; each returns the same value.
- Read-during-write, same address, same cycle (without the optional feature): the read returns the old value. The new value appears after the rising edge.
- Address inputs are exactly ADDR_W bits; there are no out-of-range addresses.
- Uninitialised state does not exist after the first reset. Before any reset, contents are undefined, except that register 0 reads 0.

Optional Feature:
- Macro: BANCO_REG_BYPASS_EN.
- Defined:
  - Write-through forwarding is enabled.
  - If RegWrite=1, rst=0, WriteRegister≠0 and ReadRegisterN==WriteRegister, then ReadDataN = data combinationally in the same cycle.
  - Each port is forwarded independently.
- Not defined:
  - No forwarding.
  - Reads return stored contents only (old value during a same-cycle write).

Test Plan:
- Fill: after reset, for i=1..31 write 12*i to reg i (RegWrite=1), one per cycle. Then ReadRegister1=26 -> ReadData1=312 and ReadRegister2=27 -> ReadData2=324.
- Overwrite: RegWrite=1, WriteRegister=18, data=70, one edge. Then ReadRegister1=18 -> 70 and ReadRegister2=27 -> 324.
- Write disable: RegWrite=0, WriteRegister=18, data=15, several edges. Then ReadRegister1=18 -> still 70 and ReadRegister2=0 -> 0.
- Zero register: RegWrite=1, WriteRegister=0, data=0xDEADBEEF, one edge. Then ReadRegister1=0 and ReadRegister2=0 -> both 0.
- Dual read / same-cycle write:
  - Setup: reg 15 holds 180; RegWrite=1, WriteRegister=15, data=99; ReadRegister1=ReadRegister2=15.
  - Before the edge: both ports read 180 without the macro, 99 with BANCO_REG_BYPASS_EN.
  - After the edge: both ports read 99.
- Reset mid-operation:
  - Setup: registers filled as in the first scenario; assert rst=1 together with RegWrite=1, WriteRegister=30, data=5.
  - After the edge: reads of 30, 26 and 18 all return 0.
